// File: rtl/dense_layer_scheduler.sv
// Issue sequencer for the non-stallable dense layer: credit-throttled input issue plus a
// tag pipeline that marks when each result leaves the layer.
module dense_layer_scheduler #(
  parameter int unsigned LATENCY = 6,
  parameter int unsigned N_STEPS = 8,
  parameter int unsigned CREDITS = 4,
  localparam int unsigned SW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1,
  localparam int unsigned CW = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          dp_issue,
  output logic [SW-1:0] step_idx,
  output logic          res_valid,
  output logic [SW-1:0] res_step,
  output logic          res_last,
  input  logic          buf_pop,
  output logic [CW-1:0] credits,
  output logic          done,
  output logic          err
);

  localparam logic [SW-1:0] LastStep    = SW'(N_STEPS - 1);
  localparam logic [CW-1:0] FullCredits = CW'(CREDITS);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            last_issue;

  logic [LATENCY-1:0] tag_valid_q;
  logic [LATENCY-1:0] tag_last_q;
  logic [SW-1:0]      tag_step_q [LATENCY];

  // in_ready depends only on registered state, never on in_valid or buf_pop.
  assign in_ready   = (state_q == StRun) && (credits_q != '0);
  assign dp_issue   = in_valid && in_ready;
  assign last_issue = dp_issue && (step_q == LastStep);
  assign busy       = (state_q != StIdle);
  assign step_idx   = step_q;
  assign credits    = credits_q;
  assign err        = err_q;
  assign done       = done_q;

  assign res_valid = tag_valid_q[LATENCY-1];
  assign res_step  = tag_step_q[LATENCY-1];
  assign res_last  = tag_last_q[LATENCY-1];

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (last_issue) state_d = StDrain;
      end
      StDrain: begin
        if (res_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    step_d = step_q;
    if ((state_q == StIdle) && start) begin
      step_d = '0;
    end else if (dp_issue) begin
      step_d = (step_q == LastStep) ? '0 : step_q + SW'(1);
    end
  end

  // A pop with the buffer already fully credited is a protocol error: flag it, keep the count.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (dp_issue && !buf_pop) begin
      credits_d = credits_q - CW'(1);
    end else if (!dp_issue && buf_pop) begin
      if (credits_q == FullCredits) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      step_q    <= '0;
      credits_q <= FullCredits;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  // Free-running shift; idle slots carry zero step so res_step is quiet between results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid_q <= '0;
      tag_last_q  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_step_q[i] <= '0;
      end
    end else begin
      tag_valid_q[0] <= dp_issue;
      tag_last_q[0]  <= last_issue;
      tag_step_q[0]  <= dp_issue ? step_q : '0;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_last_q[i]  <= tag_last_q[i-1];
        tag_step_q[i]  <= tag_step_q[i-1];
      end
    end
  end

endmodule
